// File: rtl/ysyx_23060077_mem_arbiter.sv
// Three-way arbiter (IFU read, LSU read, LSU write) onto one core-side memory master port.
// Define YSYX_23060077_ARB_RR_EN for round-robin LSU-vs-IFU selection; default is fixed priority.
module ysyx_23060077_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8,
  parameter int SIZE_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifu_r_valid_i,
  input  logic [ADDR_W-1:0] ifu_r_addr_i,
  input  logic [LEN_W-1:0]  ifu_r_len_i,
  output logic              ifu_r_ready_o,
  output logic [DATA_W-1:0] ifu_r_data_o,
  output logic              ifu_r_last_o,
  input  logic              lsu_r_valid_i,
  input  logic [ADDR_W-1:0] lsu_r_addr_i,
  input  logic [LEN_W-1:0]  lsu_r_len_i,
  output logic              lsu_r_ready_o,
  output logic [DATA_W-1:0] lsu_r_data_o,
  output logic              lsu_r_last_o,
  input  logic              lsu_w_valid_i,
  input  logic [ADDR_W-1:0] lsu_w_addr_i,
  input  logic [DATA_W-1:0] lsu_w_data_i,
  input  logic [SIZE_W-1:0] lsu_w_size_i,
  input  logic [LEN_W-1:0]  lsu_w_len_i,
  output logic              lsu_w_ready_o,
  output logic              lsu_w_last_o,
  output logic              mst_r_valid_o,
  output logic [ADDR_W-1:0] mst_r_addr_o,
  output logic [LEN_W-1:0]  mst_r_len_o,
  input  logic              mst_r_ready_i,
  input  logic [DATA_W-1:0] mst_r_data_i,
  input  logic              mst_r_last_i,
  output logic              mst_w_valid_o,
  output logic [ADDR_W-1:0] mst_w_addr_o,
  output logic [DATA_W-1:0] mst_w_data_o,
  output logic [SIZE_W-1:0] mst_w_size_o,
  output logic [LEN_W-1:0]  mst_w_len_o,
  input  logic              mst_w_ready_i,
  input  logic              mst_w_last_i,
  output logic              arb_busy_o
);

  typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_t;

  state_t state, state_nxt;
  logic   done;
  logic   ifu_first;

  // Grant ends on the ready & last beat of whichever channel currently owns the port.
  always_comb begin
    done = 1'b0;
    unique case (state)
      IFU_RD, LSU_RD: done = mst_r_ready_i & mst_r_last_i;
      LSU_WR:         done = mst_w_ready_i & mst_w_last_i;
      default:        done = 1'b0;
    endcase
  end

`ifdef YSYX_23060077_ARB_RR_EN
  logic last_lsu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_lsu <= 1'b0;
    else if (done) last_lsu <= (state != IFU_RD);
  end

  assign ifu_first = last_lsu;
`else
  assign ifu_first = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (ifu_first && ifu_r_valid_i && (lsu_w_valid_i || lsu_r_valid_i)) state_nxt = IFU_RD;
        else if (lsu_w_valid_i) state_nxt = LSU_WR;
        else if (lsu_r_valid_i) state_nxt = LSU_RD;
        else if (ifu_r_valid_i) state_nxt = IFU_RD;
      end
      default: if (done) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ifu_r_ready_o = 1'b0;
    ifu_r_data_o  = '0;
    ifu_r_last_o  = 1'b0;
    lsu_r_ready_o = 1'b0;
    lsu_r_data_o  = '0;
    lsu_r_last_o  = 1'b0;
    lsu_w_ready_o = 1'b0;
    lsu_w_last_o  = 1'b0;
    mst_r_valid_o = 1'b0;
    mst_r_addr_o  = '0;
    mst_r_len_o   = '0;
    mst_w_valid_o = 1'b0;
    mst_w_addr_o  = '0;
    mst_w_data_o  = '0;
    mst_w_size_o  = '0;
    mst_w_len_o   = '0;
    unique case (state)
      IFU_RD: begin
        mst_r_valid_o = ifu_r_valid_i;
        mst_r_addr_o  = ifu_r_addr_i;
        mst_r_len_o   = ifu_r_len_i;
        ifu_r_ready_o = mst_r_ready_i;
        ifu_r_data_o  = mst_r_data_i;
        ifu_r_last_o  = mst_r_last_i;
      end
      LSU_RD: begin
        mst_r_valid_o = lsu_r_valid_i;
        mst_r_addr_o  = lsu_r_addr_i;
        mst_r_len_o   = lsu_r_len_i;
        lsu_r_ready_o = mst_r_ready_i;
        lsu_r_data_o  = mst_r_data_i;
        lsu_r_last_o  = mst_r_last_i;
      end
      LSU_WR: begin
        mst_w_valid_o = lsu_w_valid_i;
        mst_w_addr_o  = lsu_w_addr_i;
        mst_w_data_o  = lsu_w_data_i;
        mst_w_size_o  = lsu_w_size_i;
        mst_w_len_o   = lsu_w_len_i;
        lsu_w_ready_o = mst_w_ready_i;
        lsu_w_last_o  = mst_w_last_i;
      end
      default: ;
    endcase
  end

  assign arb_busy_o = (state != IDLE);

`ifndef SYNTHESIS
  // Debug-only beat counter: last must coincide with beat number len-1 of the grant.
  logic [LEN_W-1:0] beat_cnt;
  logic [LEN_W-1:0] len_sel;
  logic             beat;
  logic             beat_last;

  always_comb begin
    len_sel   = ifu_r_len_i;
    beat      = 1'b0;
    beat_last = 1'b0;
    unique case (state)
      IFU_RD: begin beat = mst_r_ready_i; beat_last = mst_r_ready_i & mst_r_last_i; end
      LSU_RD: begin len_sel = lsu_r_len_i; beat = mst_r_ready_i; beat_last = mst_r_ready_i & mst_r_last_i; end
      LSU_WR: begin len_sel = lsu_w_len_i; beat = mst_w_ready_i; beat_last = mst_w_ready_i & mst_w_last_i; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              beat_cnt <= '0;
    else if (state == IDLE)  beat_cnt <= '0;
    else if (beat)           beat_cnt <= beat_cnt + LEN_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst_n && beat_last) assert (beat_cnt == len_sel - LEN_W'(1));
  end
`endif

endmodule

// File: tb/tb_ysyx_23060077_mem_arbiter.sv
// Randomized bench for ysyx_23060077_mem_arbiter against a transaction-level ownership model.
module tb_ysyx_23060077_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int SW = 3;
`ifdef YSYX_23060077_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ifu_r_valid_i, ifu_r_ready_o, ifu_r_last_o;
  logic [AW-1:0] ifu_r_addr_i;
  logic [LW-1:0] ifu_r_len_i;
  logic [DW-1:0] ifu_r_data_o;
  logic          lsu_r_valid_i, lsu_r_ready_o, lsu_r_last_o;
  logic [AW-1:0] lsu_r_addr_i;
  logic [LW-1:0] lsu_r_len_i;
  logic [DW-1:0] lsu_r_data_o;
  logic          lsu_w_valid_i, lsu_w_ready_o, lsu_w_last_o;
  logic [AW-1:0] lsu_w_addr_i;
  logic [DW-1:0] lsu_w_data_i;
  logic [SW-1:0] lsu_w_size_i;
  logic [LW-1:0] lsu_w_len_i;
  logic          mst_r_valid_o, mst_r_ready_i, mst_r_last_i;
  logic [AW-1:0] mst_r_addr_o;
  logic [LW-1:0] mst_r_len_o;
  logic [DW-1:0] mst_r_data_i;
  logic          mst_w_valid_o, mst_w_ready_i, mst_w_last_i;
  logic [AW-1:0] mst_w_addr_o;
  logic [DW-1:0] mst_w_data_o;
  logic [SW-1:0] mst_w_size_o;
  logic [LW-1:0] mst_w_len_o;
  logic          arb_busy_o;

  always #5 clk = ~clk;

  ysyx_23060077_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .SIZE_W(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_r_valid_i(ifu_r_valid_i), .ifu_r_addr_i(ifu_r_addr_i), .ifu_r_len_i(ifu_r_len_i),
    .ifu_r_ready_o(ifu_r_ready_o), .ifu_r_data_o(ifu_r_data_o), .ifu_r_last_o(ifu_r_last_o),
    .lsu_r_valid_i(lsu_r_valid_i), .lsu_r_addr_i(lsu_r_addr_i), .lsu_r_len_i(lsu_r_len_i),
    .lsu_r_ready_o(lsu_r_ready_o), .lsu_r_data_o(lsu_r_data_o), .lsu_r_last_o(lsu_r_last_o),
    .lsu_w_valid_i(lsu_w_valid_i), .lsu_w_addr_i(lsu_w_addr_i), .lsu_w_data_i(lsu_w_data_i),
    .lsu_w_size_i(lsu_w_size_i), .lsu_w_len_i(lsu_w_len_i),
    .lsu_w_ready_o(lsu_w_ready_o), .lsu_w_last_o(lsu_w_last_o),
    .mst_r_valid_o(mst_r_valid_o), .mst_r_addr_o(mst_r_addr_o), .mst_r_len_o(mst_r_len_o),
    .mst_r_ready_i(mst_r_ready_i), .mst_r_data_i(mst_r_data_i), .mst_r_last_i(mst_r_last_i),
    .mst_w_valid_o(mst_w_valid_o), .mst_w_addr_o(mst_w_addr_o), .mst_w_data_o(mst_w_data_o),
    .mst_w_size_o(mst_w_size_o), .mst_w_len_o(mst_w_len_o),
    .mst_w_ready_i(mst_w_ready_i), .mst_w_last_i(mst_w_last_i),
    .arb_busy_o(arb_busy_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: requester index 1=IFU read, 2=LSU read, 3=LSU write; owner 0 = port free.
  int            owner = 0;
  int            beats = 0;
  bit            last_lsu = 1'b0;
  bit            pend [1:3];
  logic [AW-1:0] addr [1:3];
  logic [LW-1:0] len  [1:3];
  logic [DW-1:0] wdata;
  logic [SW-1:0] wsize;
  int            grants = 0;

  task automatic new_req(input int i);
    pend[i] = 1'b1;
    addr[i] = $urandom;
    len[i]  = LW'($urandom_range(4, 1));
    if (i == 3) begin
      wdata = $urandom;
      wsize = SW'($urandom_range(2, 0));
    end
  endtask

  task automatic model_reset();
    owner    = 0;
    beats    = 0;
    last_lsu = 1'b0;
  endtask

  // Advance the model by one clock edge, using the inputs the DUT just sampled.
  task automatic model_edge();
    bit rdy, lst;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (owner == 0) begin
      beats = 0;
      if (RR && pend[1] && (pend[2] || pend[3]) && last_lsu) owner = 1;
      else if (pend[3]) owner = 3;
      else if (pend[2]) owner = 2;
      else if (pend[1]) owner = 1;
      if (owner != 0) grants++;
    end else begin
      rdy = (owner == 3) ? mst_w_ready_i : mst_r_ready_i;
      lst = (owner == 3) ? mst_w_last_i  : mst_r_last_i;
      if (rdy && lst) begin
        pend[owner] = 1'b0;
        last_lsu    = (owner != 1);
        owner       = 0;
      end else if (rdy) begin
        beats++;
      end
    end
  endtask

  task automatic apply_reqs();
    ifu_r_valid_i = pend[1]; ifu_r_addr_i = addr[1]; ifu_r_len_i = len[1];
    lsu_r_valid_i = pend[2]; lsu_r_addr_i = addr[2]; lsu_r_len_i = len[2];
    lsu_w_valid_i = pend[3]; lsu_w_addr_i = addr[3]; lsu_w_len_i = len[3];
    lsu_w_data_i  = wdata;   lsu_w_size_i = wsize;
  endtask

  // Memory side: well-formed beats on the owned channel, random noise elsewhere.
  task automatic respond();
    bit rdy;
    mst_r_data_i  = $urandom;
    mst_r_ready_i = 1'($urandom_range(1));
    mst_r_last_i  = 1'($urandom_range(1));
    mst_w_ready_i = 1'($urandom_range(1));
    mst_w_last_i  = 1'($urandom_range(1));
    if (owner != 0) begin
      rdy = ($urandom_range(2) != 0);
      if (owner == 3) begin
        mst_w_ready_i = rdy;
        mst_w_last_i  = rdy ? (beats == int'(len[3]) - 1) : 1'($urandom_range(1));
      end else begin
        mst_r_ready_i = rdy;
        mst_r_last_i  = rdy ? (beats == int'(len[owner]) - 1) : 1'($urandom_range(1));
      end
    end
  endtask

  task automatic check_outputs();
    bit own_i = (owner == 1);
    bit own_r = (owner == 2);
    bit own_w = (owner == 3);
    check("mst_r_valid", mst_r_valid_o, own_i ? pend[1] : own_r ? pend[2] : 1'b0);
    check("mst_r_addr",  mst_r_addr_o,  own_i ? addr[1] : own_r ? addr[2] : '0);
    check("mst_r_len",   mst_r_len_o,   own_i ? len[1]  : own_r ? len[2]  : '0);
    check("mst_w_valid", mst_w_valid_o, own_w & pend[3]);
    check("mst_w_addr",  mst_w_addr_o,  own_w ? addr[3] : '0);
    check("mst_w_data",  mst_w_data_o,  own_w ? wdata   : '0);
    check("mst_w_size",  mst_w_size_o,  own_w ? wsize   : '0);
    check("mst_w_len",   mst_w_len_o,   own_w ? len[3]  : '0);
    check("ifu_ready",   ifu_r_ready_o, own_i & mst_r_ready_i);
    check("ifu_data",    ifu_r_data_o,  own_i ? mst_r_data_i : '0);
    check("ifu_last",    ifu_r_last_o,  own_i & mst_r_last_i);
    check("lsu_r_ready", lsu_r_ready_o, own_r & mst_r_ready_i);
    check("lsu_r_data",  lsu_r_data_o,  own_r ? mst_r_data_i : '0);
    check("lsu_r_last",  lsu_r_last_o,  own_r & mst_r_last_i);
    check("lsu_w_ready", lsu_w_ready_o, own_w & mst_w_ready_i);
    check("lsu_w_last",  lsu_w_last_o,  own_w & mst_w_last_i);
    check("arb_busy",    arb_busy_o,    owner != 0);
  endtask

  initial begin
    bit did_mid = 1'b0;
    bit release_next = 1'b0;
    wdata = '0;
    wsize = '0;
    for (int i = 1; i <= 3; i++) new_req(i);
    apply_reqs();
    respond();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      model_edge();
      #1;
      if (cyc == 3 || release_next) begin
        rst_n = 1'b1;
        release_next = 1'b0;
      end
      if (cyc > 3) begin
        for (int i = 1; i <= 3; i++)
          if (!pend[i] && $urandom_range(3) == 0) new_req(i);
      end
      apply_reqs();
      respond();
      #1;
      check_outputs();
      if (cyc >= 800 && !did_mid && owner == 2) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        did_mid = 1'b1;
        release_next = 1'b1;
      end
    end
    check("mid_grant_reset_done", did_mid, 1'b1);
    check("grants_seen_gt_100", grants > 100, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
